bus_receiver: RTL and testbench

Receiving end of the shared tri-state data bus. Whenever the bus-enable strobe is high, the block samples the bus on the rising clock edge and pushes the word into a small FIFO. The FIFO presents words downstream through a valid/ready handshake. The block flags overflow and, optionally, floating-bus reads. It sits on the consumer side of every `tri_state_buffer` driver, for example at the memory and instruction-register inputs.

---
 rtl/bus_pkg.sv | 24 ++
 rtl/bus_receiver_if.sv | 33 +++
 rtl/bus_rx_fifo.sv | 102 ++++++++++
 rtl/bus_receiver.sv | 95 +++++++++
 tb/tb_bus_receiver.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared definitions for the bus receiver slice.
//   BUS_WIDTH / FIFO_DEPTH : default data width and FIFO depth
//   ptr_width()            : pointer width (index bits plus one wrap bit)
//   bus_word_t             : one bus word at the default width
//   fifo_state_e           : occupancy state derived from the FIFO pointers
package bus_pkg;

  localparam int BUS_WIDTH  = 8;
  localparam int FIFO_DEPTH = 4;

  typedef logic [BUS_WIDTH-1:0] bus_word_t;

  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_e;

  // Index bits plus the wrap bit that tells full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bus_receiver_if.sv
// bus_receiver_if: bus-side and downstream-side signals of the bus receiver.
//   data_en, data_bus   : bus-enable strobe and shared tri-state data net
//   out_ready, clr_err  : downstream ready and sticky-flag clear
//   out_data, out_valid : head-of-FIFO word and its valid flag
//   count               : FIFO occupancy 0..DEPTH
//   overflow, float_err : sticky error flags
// Modports: master (drives the bus and consumes words), slave (the receiver).
interface bus_receiver_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);

  logic                     data_en;
  logic [WIDTH-1:0]         data_bus;
  logic                     out_ready;
  logic                     clr_err;
  logic [WIDTH-1:0]         out_data;
  logic                     out_valid;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     float_err;

  modport master (
    output data_en, data_bus, out_ready, clr_err,
    input  out_data, out_valid, count, overflow, float_err
  );

  modport slave (
    input  data_en, data_bus, out_ready, clr_err,
    output out_data, out_valid, count, overflow, float_err
  );

endinterface

// File: rtl/bus_rx_fifo.sv
// bus_rx_fifo: storage, pointers and occupancy for the bus receiver.
//   clk, rst_n : clock and asynchronous active-low reset (empties the FIFO)
//   push       : request to store push_data (dropped when full without a pop)
//   pop        : request to retire the head word (ignored when empty)
//   head_data  : head entry, zero while empty
//   full/empty : occupancy state decoded from the pointers
//   count      : occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module bus_rx_fifo
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head_data,
  output logic                          full,
  output logic                          empty,
  output logic [ptr_width(DEPTH)-1:0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  fifo_state_e      fifo_state_s;
  logic             push_s;
  logic             pop_s;

  // Decode the occupancy state from the pointer pair.
  always_comb begin
    fifo_state_s = FIFO_PARTIAL;
    if (wr_ptr_r == rd_ptr_r) begin
      fifo_state_s = FIFO_EMPTY;
    end else if ((wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]) &&
                 (wr_ptr_r[IDX_W] != rd_ptr_r[IDX_W])) begin
      fifo_state_s = FIFO_FULL;
    end else begin
      fifo_state_s = FIFO_PARTIAL;
    end
  end

  // Qualify the requests: a pop frees a slot for a same-cycle push.
  always_comb begin
    empty  = 1'b0;
    full   = 1'b0;
    case (fifo_state_s)
      FIFO_EMPTY:   empty = 1'b1;
      FIFO_FULL:    full  = 1'b1;
      FIFO_PARTIAL: begin
        empty = 1'b0;
        full  = 1'b0;
      end
      default: begin
        empty = 1'b0;
        full  = 1'b0;
      end
    endcase
    pop_s  = pop & ~empty;
    push_s = push & (~full | pop_s);
  end

  // Pointer registers; reset discards any stored words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Word storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[IDX_W-1:0]] <= push_data;
    end
  end

  // Head word is presented combinationally and forced to zero when empty.
  always_comb begin
    if (empty) begin
      head_data = {WIDTH{1'b0}};
    end else begin
      head_data = mem_r[rd_ptr_r[IDX_W-1:0]];
    end
  end

  assign count = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/bus_receiver.sv
// bus_receiver: samples the shared tri-state bus while data_en is high and
// queues the words for a valid/ready consumer.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : bus_receiver_if.slave (strobe, bus, handshake, count, flags)
// Optional macro BUS_FLOAT_CHECK_EN: drop samples containing X/Z bits and
// raise float_err (simulation-only check); without it float_err is tied low.
module bus_receiver
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  bus_receiver_if.slave   bus
);

  logic             full_s;
  logic             empty_s;
  logic             pop_s;
  logic             float_bad_s;
  logic             push_req_s;
  logic             ovf_set_s;
  logic             overflow_r;
  logic [WIDTH-1:0] head_s;

  // Detect an enabled-but-undriven bus and qualify push/overflow.
  always_comb begin
`ifdef BUS_FLOAT_CHECK_EN
    if ((^bus.data_bus) === 1'bx) begin
      float_bad_s = 1'b1;
    end else begin
      float_bad_s = 1'b0;
    end
`else
    float_bad_s = 1'b0;
`endif
    pop_s      = ~empty_s & bus.out_ready;
    push_req_s = bus.data_en & ~float_bad_s;
    ovf_set_s  = push_req_s & full_s & ~pop_s;
  end

  bus_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req_s),
    .push_data (bus.data_bus),
    .pop       (pop_s),
    .head_data (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (bus.count)
  );

  // Sticky overflow flag; a set event beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (ovf_set_s) begin
      overflow_r <= 1'b1;
    end else if (bus.clr_err) begin
      overflow_r <= 1'b0;
    end
  end

`ifdef BUS_FLOAT_CHECK_EN
  logic float_err_r;
  logic float_set_s;

  assign float_set_s = bus.data_en & float_bad_s;

  // Sticky floating-bus flag; a set event beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      float_err_r <= 1'b0;
    end else if (float_set_s) begin
      float_err_r <= 1'b1;
    end else if (bus.clr_err) begin
      float_err_r <= 1'b0;
    end
  end

  assign bus.float_err = float_err_r;
`else
  assign bus.float_err = 1'b0;
`endif

  assign bus.out_data  = head_s;
  assign bus.out_valid = ~empty_s;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_bus_receiver.sv
// tb_bus_receiver: directed bench for bus_receiver with a queue-based model
// and a per-cycle comparator, plus literal checks for the key scenarios.
// Builds with or without BUS_FLOAT_CHECK_EN.
module tb_bus_receiver;

  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int tests = 0;
  int fails = 0;

  bus_receiver_if #(.WIDTH(W), .DEPTH(D)) bif ();

  bus_receiver #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO as a queue plus two sticky bits.
  logic [W-1:0] mq[$];
  bit m_ovf = 1'b0;
  bit m_flt = 1'b0;
  bit m_pop, m_push, m_bad, m_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_flt = 1'b0;
    end else begin
      m_pop = (mq.size() != 0) && (bif.out_ready === 1'b1);
      m_bad = 1'b0;
`ifdef BUS_FLOAT_CHECK_EN
      m_bad = $isunknown(bif.data_bus);
`endif
      m_push = (bif.data_en === 1'b1) && !m_bad;
      m_acc  = m_push && ((mq.size() < D) || m_pop);
      if (m_pop) void'(mq.pop_front());
      if (m_acc) mq.push_back(bif.data_bus);
      if (m_push && !m_acc) m_ovf = 1'b1;
      else if (bif.clr_err === 1'b1) m_ovf = 1'b0;
      if ((bif.data_en === 1'b1) && m_bad) m_flt = 1'b1;
      else if (bif.clr_err === 1'b1) m_flt = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_valid", {31'd0, bif.out_valid}, {31'd0, mq.size() != 0});
      check("cmp_data", {24'd0, bif.out_data}, (mq.size() != 0) ? {24'd0, mq[0]} : 32'd0);
      check("cmp_count", {29'd0, bif.count}, mq.size());
      check("cmp_overflow", {31'd0, bif.overflow}, {31'd0, m_ovf});
      check("cmp_float", {31'd0, bif.float_err}, {31'd0, m_flt});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bif.data_en   = 1'b0;
    bif.data_bus  = 8'h00;
    bif.out_ready = 1'b0;
    bif.clr_err   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_valid", {31'd0, bif.out_valid}, 32'd0);
    check("rst_count", {29'd0, bif.count}, 32'd0);
    check("rst_data", {24'd0, bif.out_data}, 32'd0);
    check("rst_overflow", {31'd0, bif.overflow}, 32'd0);

    // Single word
    bif.data_en = 1'b1; bif.data_bus = 8'h55;
    step();
    bif.data_en = 1'b0;
    check("single_valid", {31'd0, bif.out_valid}, 32'd1);
    check("single_data", {24'd0, bif.out_data}, 32'h55);
    check("single_count", {29'd0, bif.count}, 32'd1);
    bif.out_ready = 1'b1;
    step();
    bif.out_ready = 1'b0;
    check("single_drained", {29'd0, bif.count}, 32'd0);

    // Fill and overflow
    for (int i = 1; i <= 5; i++) begin
      bif.data_en = 1'b1; bif.data_bus = 8'(i);
      step();
    end
    bif.data_en = 1'b0;
    check("fill_count", {29'd0, bif.count}, 32'd4);
    check("fill_overflow", {31'd0, bif.overflow}, 32'd1);
    bif.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("fill_drain_data", {24'd0, bif.out_data}, 32'(k + 1));
      step();
    end
    bif.out_ready = 1'b0;
    check("fill_empty", {31'd0, bif.out_valid}, 32'd0);
    bif.clr_err = 1'b1;
    step();
    bif.clr_err = 1'b0;
    check("ovf_cleared", {31'd0, bif.overflow}, 32'd0);

    // Full with simultaneous push and pop
    for (int i = 1; i <= 4; i++) begin
      bif.data_en = 1'b1; bif.data_bus = 8'(i);
      step();
    end
    bif.out_ready = 1'b1; bif.data_bus = 8'hAA;
    step();
    bif.data_en = 1'b0;
    check("fullpp_count", {29'd0, bif.count}, 32'd4);
    check("fullpp_overflow", {31'd0, bif.overflow}, 32'd0);
    check("fullpp_d0", {24'd0, bif.out_data}, 32'h02); step();
    check("fullpp_d1", {24'd0, bif.out_data}, 32'h03); step();
    check("fullpp_d2", {24'd0, bif.out_data}, 32'h04); step();
    check("fullpp_d3", {24'd0, bif.out_data}, 32'hAA); step();
    bif.out_ready = 1'b0;
    check("fullpp_empty", {29'd0, bif.count}, 32'd0);

    // Wrap-around at steady occupancy of one
    bif.data_en = 1'b1; bif.data_bus = 8'h10;
    step();
    bif.out_ready = 1'b1;
    for (int i = 1; i < 10; i++) begin
      bif.data_bus = 8'(8'h10 + i);
      check("wrap_data", {24'd0, bif.out_data}, 32'(8'h10 + i - 1));
      step();
      check("wrap_count", {29'd0, bif.count}, 32'd1);
    end
    bif.data_en = 1'b0;
    check("wrap_last", {24'd0, bif.out_data}, 32'h19);
    step();
    bif.out_ready = 1'b0;
    check("wrap_empty", {29'd0, bif.count}, 32'd0);

`ifdef BUS_FLOAT_CHECK_EN
    // Floating-bus detection
    bif.data_en = 1'b1; bif.data_bus = 'z;
    step();
    check("float_set", {31'd0, bif.float_err}, 32'd1);
    check("float_count", {29'd0, bif.count}, 32'd0);
    bif.clr_err = 1'b1;
    step();
    check("float_set_wins", {31'd0, bif.float_err}, 32'd1);
    bif.data_en = 1'b0; bif.data_bus = 8'h00;
    step();
    bif.clr_err = 1'b0;
    check("float_cleared", {31'd0, bif.float_err}, 32'd0);
`endif

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      bif.data_en = 1'b1; bif.data_bus = 8'(8'h30 + i);
      step();
    end
    bif.data_en = 1'b0;
    check("pre_rst_count", {29'd0, bif.count}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bif.out_valid}, 32'd0);
    check("arst_count", {29'd0, bif.count}, 32'd0);
    check("arst_data", {24'd0, bif.out_data}, 32'd0);
    check("arst_overflow", {31'd0, bif.overflow}, 32'd0);
    check("arst_float", {31'd0, bif.float_err}, 32'd0);
    rst_n = 1'b1;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
